// File: rtl/pred_mask_stack_pkg.sv
// Shared SM-core constants for the predicate mask stack: default lane count,
// stack depth, and the decoded CU strobe command.
package pred_mask_stack_pkg;

   localparam int PMS_NUM_LANES = 8;
   localparam int PMS_DEPTH     = 8;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_COMP,
      OP_MULTI
   } pms_op_e;

   // Collapse the three one-hot strobes into a single command; any overlap is a protocol error.
   function automatic pms_op_e decode_op(input logic push, input logic pop, input logic comp);
      pms_op_e op;
      case ({push, pop, comp})
         3'b000:  op = OP_NONE;
         3'b100:  op = OP_PUSH;
         3'b010:  op = OP_POP;
         3'b001:  op = OP_COMP;
         default: op = OP_MULTI;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/pred_mask_stack.sv
// Nested IF/ELSE/ENDIF active-lane mask stack. The base entry is implicitly
// all-ones, so only the nested entries are stored.
module pred_mask_stack
   import pred_mask_stack_pkg::*;
#(
   parameter int NUM_LANES = PMS_NUM_LANES,
   parameter int DEPTH     = PMS_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_LANES-1:0]     pred_in,
   input  logic                     pstack_push,
   input  logic                     pstack_pop,
   input  logic                     pstack_complement,
   output logic [NUM_LANES-1:0]     active_mask,
   output logic                     all_mask_false,
   output logic                     all_mask_true,
   output logic [$clog2(DEPTH)-1:0] depth,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     proto_err
);

   localparam int DW = $clog2(DEPTH);
   localparam logic [DW-1:0] TOP = DW'(DEPTH - 1);

   logic [NUM_LANES-1:0] r_stk [DEPTH];
   logic [DW-1:0]        r_depth;
   logic                 r_overflow;
   logic                 r_underflow;
   logic                 r_proto_err;

   logic [NUM_LANES-1:0] w_active;
   logic [NUM_LANES-1:0] w_parent;
   pms_op_e              w_op;
   logic                 w_push_ok;
   logic                 w_comp_ok;

   assign w_op      = decode_op(pstack_push, pstack_pop, pstack_complement);
   assign w_push_ok = (w_op == OP_PUSH) && (r_depth != TOP);
   assign w_comp_ok = (w_op == OP_COMP) && (r_depth != '0);

   // Entry 0 is never written: level 0 and its parent both read as all-ones.
   always_comb begin
      w_active = '1;
      w_parent = '1;
      if (r_depth != '0)
         w_active = r_stk[r_depth];
      if (r_depth > DW'(1))
         w_parent = r_stk[r_depth - DW'(1)];
   end

   assign active_mask    = w_active;
   assign all_mask_false = ((w_active & pred_in) == '0);
   assign all_mask_true  = (w_active == w_parent);
   assign depth          = r_depth;
   assign overflow       = r_overflow;
   assign underflow      = r_underflow;
   assign proto_err      = r_proto_err;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_depth     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         case (w_op)
            OP_PUSH: begin
               if (r_depth == TOP) r_overflow <= 1'b1;
               else                r_depth    <= r_depth + DW'(1);
            end
            OP_POP: begin
               if (r_depth == '0) r_underflow <= 1'b1;
               else               r_depth     <= r_depth - DW'(1);
            end
            OP_COMP: begin
               if (r_depth == '0) r_underflow <= 1'b1;
            end
            OP_MULTI: r_proto_err <= 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the mask array has no reset; entries above depth are don't-care and are always written before being read.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_push_ok)
            r_stk[r_depth + DW'(1)] <= w_active & pred_in;
         else if (w_comp_ok)
            r_stk[r_depth] <= w_parent & ~w_active;
      end
   end

endmodule

// File: tb/tb_pred_mask_stack.sv
// Directed bench for pred_mask_stack at NUM_LANES=8, DEPTH=4.
module tb_pred_mask_stack;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pred_in;
   logic       pstack_push;
   logic       pstack_pop;
   logic       pstack_complement;
   logic [7:0] active_mask;
   logic       all_mask_false;
   logic       all_mask_true;
   logic [1:0] depth;
   logic       overflow;
   logic       underflow;
   logic       proto_err;

   int total = 0;
   int bad   = 0;

   pred_mask_stack #(.NUM_LANES(8), .DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .pred_in           (pred_in),
      .pstack_push       (pstack_push),
      .pstack_pop        (pstack_pop),
      .pstack_complement (pstack_complement),
      .active_mask       (active_mask),
      .all_mask_false    (all_mask_false),
      .all_mask_true     (all_mask_true),
      .depth             (depth),
      .overflow          (overflow),
      .underflow         (underflow),
      .proto_err         (proto_err)
   );

   always #5 clk = ~clk;

   // One-cycle command: asserted at negedge, sampled at posedge, released 1 ns later.
   task automatic cmd(input logic pu, input logic po, input logic co);
      @(negedge clk);
      pstack_push = pu; pstack_pop = po; pstack_complement = co;
      @(posedge clk);
      #1;
      pstack_push = 1'b0; pstack_pop = 1'b0; pstack_complement = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; pred_in = 8'h00;
      pstack_push = 1'b0; pstack_pop = 1'b0; pstack_complement = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      total++; if (active_mask !== 8'hFF) begin bad++; $display("FAIL reset_mask got=%h exp=ff", active_mask); end
      total++; if (depth !== 2'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
      total++; if (all_mask_true !== 1'b1) begin bad++; $display("FAIL reset_amt got=%b exp=1", all_mask_true); end
      total++; if (all_mask_false !== 1'b1) begin bad++; $display("FAIL reset_amf got=%b exp=1", all_mask_false); end
      total++; if ({overflow, underflow, proto_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {overflow, underflow, proto_err}); end
   endtask

   task automatic test_if_else;
      pred_in = 8'h0F; #1;
      total++; if (all_mask_false !== 1'b0) begin bad++; $display("FAIL ie_amf got=%b exp=0", all_mask_false); end
      cmd(1, 0, 0);
      total++; if (active_mask !== 8'h0F || depth !== 2'd1) begin bad++; $display("FAIL ie_push got=%h/%0d exp=0f/1", active_mask, depth); end
      total++; if (all_mask_true !== 1'b0) begin bad++; $display("FAIL ie_amt got=%b exp=0", all_mask_true); end
      cmd(0, 0, 1);
      total++; if (active_mask !== 8'hF0 || depth !== 2'd1) begin bad++; $display("FAIL ie_comp got=%h/%0d exp=f0/1", active_mask, depth); end
      cmd(0, 1, 0);
      total++; if (active_mask !== 8'hFF || depth !== 2'd0) begin bad++; $display("FAIL ie_pop got=%h/%0d exp=ff/0", active_mask, depth); end
   endtask

   task automatic test_nested;
      pred_in = 8'h0F; cmd(1, 0, 0);
      pred_in = 8'h3C; cmd(1, 0, 0);
      total++; if (active_mask !== 8'h0C || depth !== 2'd2) begin bad++; $display("FAIL nest_push2 got=%h/%0d exp=0c/2", active_mask, depth); end
      cmd(0, 0, 1);
      total++; if (active_mask !== 8'h03) begin bad++; $display("FAIL nest_comp got=%h exp=03", active_mask); end
      cmd(0, 1, 0);
      total++; if (active_mask !== 8'h0F || depth !== 2'd1) begin bad++; $display("FAIL nest_pop1 got=%h/%0d exp=0f/1", active_mask, depth); end
      cmd(0, 1, 0);
      total++; if (active_mask !== 8'hFF || depth !== 2'd0) begin bad++; $display("FAIL nest_pop2 got=%h/%0d exp=ff/0", active_mask, depth); end
   endtask

   task automatic test_all_mask;
      pred_in = 8'h00; #1;
      total++; if (all_mask_false !== 1'b1) begin bad++; $display("FAIL am_false got=%b exp=1", all_mask_false); end
      cmd(1, 0, 0);
      total++; if (active_mask !== 8'h00 || depth !== 2'd1) begin bad++; $display("FAIL am_empty_push got=%h/%0d exp=00/1", active_mask, depth); end
      cmd(0, 1, 0);
      pred_in = 8'hFF; cmd(1, 0, 0);
      total++; if (all_mask_true !== 1'b1) begin bad++; $display("FAIL am_true got=%b exp=1", all_mask_true); end
      pred_in = 8'h00; #1;
      total++; if (all_mask_false !== 1'b1) begin bad++; $display("FAIL am_false_nested got=%b exp=1", all_mask_false); end
      cmd(0, 1, 0);
      total++; if (depth !== 2'd0) begin bad++; $display("FAIL am_pop got=%0d exp=0", depth); end
   endtask

   task automatic test_back_to_back;
      pred_in = 8'hF0;
      @(negedge clk); pstack_push = 1'b1;
      repeat (2) @(posedge clk);
      #1 pstack_push = 1'b0;
      total++; if (active_mask !== 8'hF0 || depth !== 2'd2) begin bad++; $display("FAIL b2b_push got=%h/%0d exp=f0/2", active_mask, depth); end
      @(negedge clk); pstack_complement = 1'b1;
      @(posedge clk); #1 pstack_complement = 1'b0; pstack_pop = 1'b1;
      total++; if (active_mask !== 8'h00) begin bad++; $display("FAIL b2b_comp got=%h exp=00", active_mask); end
      repeat (2) @(posedge clk);
      #1 pstack_pop = 1'b0;
      total++; if (active_mask !== 8'hFF || depth !== 2'd0 || underflow !== 1'b0) begin bad++; $display("FAIL b2b_pop got=%h/%0d/%b exp=ff/0/0", active_mask, depth, underflow); end
   endtask

   task automatic test_over_under;
      pred_in = 8'h5A;
      repeat (4) cmd(1, 0, 0);
      total++; if (depth !== 2'd3 || overflow !== 1'b1) begin bad++; $display("FAIL ovf got=%0d/%b exp=3/1", depth, overflow); end
      total++; if (active_mask !== 8'h5A || underflow !== 1'b0) begin bad++; $display("FAIL ovf_hold got=%h/%b exp=5a/0", active_mask, underflow); end
      repeat (4) cmd(0, 1, 0);
      total++; if (depth !== 2'd0 || underflow !== 1'b1) begin bad++; $display("FAIL udf got=%0d/%b exp=0/1", depth, underflow); end
      cmd(0, 0, 1);
      total++; if (active_mask !== 8'hFF || depth !== 2'd0) begin bad++; $display("FAIL udf_comp got=%h/%0d exp=ff/0", active_mask, depth); end
      total++; if (overflow !== 1'b1 || proto_err !== 1'b0) begin bad++; $display("FAIL sticky got=%b/%b exp=1/0", overflow, proto_err); end
   endtask

   task automatic test_proto_reset;
      pred_in = 8'h0F; cmd(1, 0, 0);
      cmd(1, 1, 0);
      total++; if (active_mask !== 8'h0F || depth !== 2'd1 || proto_err !== 1'b1) begin bad++; $display("FAIL proto got=%h/%0d/%b exp=0f/1/1", active_mask, depth, proto_err); end
      cmd(0, 1, 1);
      total++; if (active_mask !== 8'h0F || depth !== 2'd1) begin bad++; $display("FAIL proto2 got=%h/%0d exp=0f/1", active_mask, depth); end
      pred_in = 8'h3C; cmd(1, 0, 0);
      total++; if (active_mask !== 8'h0C || depth !== 2'd2) begin bad++; $display("FAIL pre_rst got=%h/%0d exp=0c/2", active_mask, depth); end
      #2 reset = 1'b1;
      #1;
      total++; if (active_mask !== 8'hFF || depth !== 2'd0) begin bad++; $display("FAIL async_rst got=%h/%0d exp=ff/0", active_mask, depth); end
      total++; if ({overflow, underflow, proto_err} !== 3'b000) begin bad++; $display("FAIL async_flags got=%b exp=000", {overflow, underflow, proto_err}); end
      @(negedge clk); pstack_push = 1'b1;
      @(posedge clk); #1 pstack_push = 1'b0;
      total++; if (depth !== 2'd0) begin bad++; $display("FAIL rst_ignore got=%0d exp=0", depth); end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      total++; if (active_mask !== 8'hFF || depth !== 2'd0) begin bad++; $display("FAIL post_rst got=%h/%0d exp=ff/0", active_mask, depth); end
   endtask

   initial begin
      test_reset();
      test_if_else();
      test_nested();
      test_all_mask();
      test_back_to_back();
      test_over_under();
      test_proto_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
